// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad emulator and its scanner benches.
// Key map, FSM state encoding and bounce LFSR taps.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE
  } state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // x^8+x^6+x^5+x^4+1 on a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic key_pos_t key_to_pos(
    input logic [3:0] key
  );
    key_pos_t p;
    p = '0;
    unique case (key)
      4'h1: p = '{2'd0, 2'd0};
      4'h2: p = '{2'd0, 2'd1};
      4'h3: p = '{2'd0, 2'd2};
      4'hA: p = '{2'd0, 2'd3};
      4'h4: p = '{2'd1, 2'd0};
      4'h5: p = '{2'd1, 2'd1};
      4'h6: p = '{2'd1, 2'd2};
      4'hB: p = '{2'd1, 2'd3};
      4'h7: p = '{2'd2, 2'd0};
      4'h8: p = '{2'd2, 2'd1};
      4'h9: p = '{2'd2, 2'd2};
      4'hC: p = '{2'd2, 2'd3};
      4'hF: p = '{2'd3, 2'd0};
      4'h0: p = '{2'd3, 2'd1};
      4'hE: p = '{2'd3, 2'd2};
      4'hD: p = '{2'd3, 2'd3};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the contact bounce source.
// Reloads the seed on reset; the seed must be nonzero.
module lfsr8
  import keypad_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else begin
      state <= {state[6:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Keypad side of a row-scan/column-sense matrix: presses one key
// per request with pseudo-random bounce on closure and release.
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        press_valid,
  output logic        press_ready,
  input  logic [3:0]  key,
  input  logic [15:0] hold_cycles,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] B_LOAD = 16'(BOUNCE_CYCLES - 1);
  localparam bit NO_BOUNCE = (BOUNCE_CYCLES == 0);

  state_t      state;
  logic        contact;
  logic [15:0] cnt;
  logic [15:0] hold_q;
  key_pos_t    pos_q;
  logic [7:0]  lfsr;

  lfsr8 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .state(lfsr)
  );

  // Counter load for a hold of max(h,1) cycles
  function automatic logic [15:0] hold_load(
    input logic [15:0] h
  );
    return (h == 16'd0) ? 16'd0 : h - 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      contact <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      hold_q  <= '0;
      pos_q   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          contact <= 1'b0;
          if (press_valid) begin
            pos_q  <= key_to_pos(key);
            hold_q <= hold_load(hold_cycles);
            if (NO_BOUNCE) begin
              state   <= HOLD;
              cnt     <= hold_load(hold_cycles);
              contact <= 1'b1;
            end else begin
              state   <= PRESS_BOUNCE;
              cnt     <= B_LOAD;
              contact <= lfsr[0];
            end
          end
        end
        PRESS_BOUNCE: begin
          if (cnt == 16'd0) begin
            state   <= HOLD;
            cnt     <= hold_q;
            contact <= 1'b1;
          end else begin
            cnt     <= cnt - 16'd1;
            contact <= lfsr[0];
          end
        end
        HOLD: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (NO_BOUNCE) begin
            state   <= IDLE;
            cnt     <= '0;
            contact <= 1'b0;
            done    <= 1'b1;
          end else begin
            state   <= RELEASE_BOUNCE;
            cnt     <= B_LOAD;
            contact <= lfsr[0];
          end
        end
        RELEASE_BOUNCE: begin
          if (cnt == 16'd0) begin
            state   <= IDLE;
            contact <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt     <= cnt - 16'd1;
            contact <= lfsr[0];
          end
        end
      endcase
    end
  end

  assign press_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Only the stored row matters; other low rows are don't-care
  assign cols = (contact && !rows[pos_q.row])
              ? (4'b0001 << pos_q.col)
              : 4'b0000;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Scoreboard bench for keypad_matrix_emulator against a
// timeline-based reference model of one press sequence.
module tb_keypad_matrix_emulator;

  localparam int         B    = 16;
  localparam logic [7:0] SEED = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic        press_valid;
  logic        press_ready;
  logic [3:0]  key;
  logic [15:0] hold_cycles;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  keypad_matrix_emulator #(
    .BOUNCE_CYCLES(B),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .press_valid(press_valid),
    .press_ready(press_ready),
    .key        (key),
    .hold_cycles(hold_cycles),
    .rows       (rows),
    .cols       (cols),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [3:0] cols;
    logic       done;
    logic       ready;
    logic       busy;
    logic [7:0] lfsr;
    bit         fall_win;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   falls       = 0;
  logic [3:0] prev_cols = 4'b0;
  bit   prev_fw = 0;

  // keypad face, row-major: row r, col c at index 4*r+c
  logic [3:0] layout [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hF, 4'h0, 4'hE, 4'hD
  };

  // reference model: time since accept plus LFSR history
  logic [7:0] m_lfsr, m_lprev;
  bit m_busy, m_done, fall_win;
  int m_t, m_h, m_row, m_col;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic fb;
    fb = s[8-1] ^ s[6-1] ^ s[5-1] ^ s[4-1];
    return {s[6:0], fb};
  endfunction

  function automatic bit in_bounce();
    return m_busy && (m_t <= B || m_t > B + m_h);
  endfunction

  task automatic push_expect();
    exp_t x;
    bit c;
    if (!m_busy)          c = 1'b0;
    else if (in_bounce()) c = m_lprev[0];
    else                  c = 1'b1;
    x.cols  = (c && !rows[m_row]) ? 4'(1 << m_col) : 4'b0000;
    x.done  = m_done;
    x.ready = !m_busy;
    x.busy  = m_busy;
    x.lfsr  = m_lfsr;
    x.fall_win = fall_win && in_bounce();
    sb.push_back(x);
  endtask

  task automatic model_edge();
    m_lprev = m_lfsr;
    m_done  = 1'b0;
    if (reset) begin
      m_lfsr = SEED;
      m_busy = 1'b0;
    end else begin
      m_lfsr = lfsr_step(m_lfsr);
      if (m_busy) begin
        m_t++;
        if (m_t == 2 * B + m_h + 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (press_valid) begin
        m_busy = 1'b1;
        m_t    = 1;
        m_h    = (hold_cycles == 0) ? 1 : int'(hold_cycles);
        for (int i = 0; i < 16; i++)
          if (layout[i] == key) begin
            m_row = i / 4;
            m_col = i % 4;
          end
      end
    end
  endtask

  task automatic tick();
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && m_busy; i++) begin
      key         = 4'($urandom);
      hold_cycles = 16'($urandom);
      tick();
    end
    if (m_busy) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: sequence still busy after %0d cycles", budget);
    end
    tick();
  endtask

  task automatic press(input logic [3:0] k, input int h);
    press_valid = 1'b1;
    key         = k;
    hold_cycles = 16'(h);
    tick();
    press_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (cols !== e.cols || done !== e.done ||
            press_ready !== e.ready || busy !== e.busy ||
            dut.lfsr !== e.lfsr) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t got cols=%b done=%b rdy=%b busy=%b lfsr=%h want cols=%b done=%b rdy=%b busy=%b lfsr=%h",
                   vectors, $time, cols, done, press_ready, busy,
                   dut.lfsr, e.cols, e.done, e.ready, e.busy, e.lfsr);
        end
        if (e.fall_win && prev_fw && prev_cols != 0 && cols == 0)
          falls++;
        prev_cols = cols;
        prev_fw   = e.fall_win;
      end
    end
  end

  initial begin
    reset = 1'b1;
    press_valid = 1'b0;
    key = 4'h0;
    hold_cycles = 16'd0;
    rows = 4'hF;
    fall_win = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_lfsr = SEED; m_lprev = SEED;
    m_busy = 1'b0; m_done = 1'b0;
    m_t = 0; m_h = 1; m_row = 0; m_col = 0;

    // reset state, with a request that must lose to reset
    press_valid = 1'b1;
    key = 4'h5;
    repeat (2) tick();
    press_valid = 1'b0;
    reset = 1'b0;
    tick();

    rows = 4'b1101;
    press(4'h5, 100);
    run_to_done(400);

    rows = 4'b1110;
    press(4'hD, 50);
    run_to_done(200);
    rows = 4'b0111;
    press(4'hD, 50);
    run_to_done(200);

    rows = 4'b1110;
    press(4'h0, 30);
    for (int i = 1; i < 200 && m_busy; i++) begin
      rows = ~(4'b0001 << (i % 4));
      tick();
    end
    tick();

    // held request, second one accepted on the done cycle
    rows = 4'b1110;
    press_valid = 1'b1;
    key = 4'h1;
    hold_cycles = 16'd10;
    tick();
    key = 4'h2;
    hold_cycles = 16'd0;
    for (int i = 0; i < 200 && m_busy; i++) tick();
    tick();
    press_valid = 1'b0;
    run_to_done(200);

    rows = 4'b1011;
    press(4'h9, 40);
    repeat (B + 10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();

    rows = 4'b0000;
    fall_win = 1'b1;
    for (int n = 0; n < 4; n++) begin
      press(4'($urandom), 5);
      run_to_done(200);
    end
    fall_win = 1'b0;

    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(99) == 0);
      press_valid = ($urandom_range(3) == 0);
      key         = 4'($urandom);
      hold_cycles = 16'($urandom_range(0, 12));
      rows        = 4'($urandom);
      tick();
    end
    reset = 1'b0;
    press_valid = 1'b0;
    tick();
    @(negedge clk);
    #1;

    vectors++;
    if (falls == 0) begin
      miscompares++;
      $display("FAIL bounce_fall: got %0d contact 1->0 edges, want >0",
               falls);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
